fetch_stage: RTL

Instruction-fetch stage of the saratoga core. Sits directly downstream of the program-counter register. Each cycle it turns the current PC into a request on the instruction-memory bus, tracks in-flight requests, and buffers returned instructions with their PCs in an in-order FIFO. It presents them to Decode with a valid/ready handshake. It drives `stall_fetch` back to the PC register and discards stale instructions on a redirect.

---
 rtl/fetch_stage.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the saratoga core.
// Turns the current PC into instruction-bus requests, tracks in-flight
// requests with a PC-tag queue, and buffers returned instructions (with PC
// and fault flag) in an in-order FIFO presented to Decode via valid/ready.
// A redirect (flush) discards buffered entries and drops pending responses.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pc                       current PC from the PC register
//   flush                    redirect: kill in-flight and buffered work
//   stall_fetch              to PC register, high = hold PC (combinational)
//   imem_req, imem_addr      bus request (combinational)
//   imem_gnt                 bus accepted the request this cycle
//   imem_rvalid/rdata/err    in-order bus response
//   inst_valid, inst,        head entry to Decode
//   inst_pc, inst_fault
//   inst_ready               Decode accepts the head entry
module fetch_stage #(
    parameter int unsigned DEPTH = 3,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        stall_fetch,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        inst_ready
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
        logic        fault;
    } entry_t;

    logic [CW-1:0] out_cnt, fifo_cnt, drop_cnt;
    logic [31:0]   tag_q [DEPTH];
    logic [PW-1:0] tag_wr, tag_rd;
    entry_t        fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    logic          aligned, cap, grant, mis_push, accepted;
    logic          resp, drop, push, pop;
    logic [CW:0]   occ;
    entry_t        push_entry, head;

    // Pointer increment modulo DEPTH
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + 1'b1);
    endfunction

    // Request, acceptance and response decode
    always_comb begin
        aligned     = (pc[1:0] == 2'b00);
        occ         = (CW+1)'(out_cnt) + (CW+1)'(fifo_cnt);
        cap         = (occ < (CW+1)'(DEPTH));
        imem_req    = ~rst & aligned & cap & ~flush;
        imem_addr   = pc;
        grant       = imem_req & imem_gnt;
        // Misaligned PCs bypass the bus but must not overtake pending responses
        mis_push    = ~rst & ~aligned & cap & ~flush & (out_cnt == '0);
        accepted    = grant | mis_push;
        stall_fetch = rst | (~flush & ~accepted);
        // A response with nothing outstanding is a protocol error and ignored
        resp        = imem_rvalid & (out_cnt != '0);
        drop        = resp & (drop_cnt != '0);
        push        = (resp & ~drop & ~flush) | mis_push;
        if (mis_push) begin
            push_entry = {pc, NOP, 1'b1};
        end else begin
            push_entry = {tag_q[tag_rd], imem_err ? NOP : imem_rdata, imem_err};
        end
        head        = fifo_q[rd_ptr];
        inst_valid  = (fifo_cnt != '0) & ~flush;
        pop         = inst_valid & inst_ready;
    end

    assign inst       = head.word;
    assign inst_pc    = head.pc;
    assign inst_fault = head.fault;

    // Counters, tag queue and instruction FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt  <= '0;
            fifo_cnt <= '0;
            drop_cnt <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i]  <= '0;
                fifo_q[i] <= '0;
            end
        end else begin
            if (grant) begin
                tag_q[tag_wr] <= pc;
                tag_wr        <= bump(tag_wr);
            end
            if (resp) begin
                tag_rd <= bump(tag_rd);
            end
            out_cnt <= out_cnt + CW'(grant) - CW'(resp);
            if (flush) begin
                // Everything still outstanding is stale after a redirect
                drop_cnt <= out_cnt - CW'(resp);
                fifo_cnt <= '0;
                rd_ptr   <= wr_ptr;
            end else begin
                drop_cnt <= drop_cnt - CW'(drop);
                if (push) begin
                    fifo_q[wr_ptr] <= push_entry;
                    wr_ptr         <= bump(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= bump(rd_ptr);
                end
                fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            end
        end
    end

endmodule
